// File: rtl/instr_encoder.sv
// Encodes MIPS-style requests into imem writes; word appears on imem_* one cycle after accept, one word per 2 cycles.
// req_ready is high only in IDLE, so requests are held off during WRITE/HALT and forever once DONE or FULL.
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [5:0]  req_funct,
   input  logic [15:0] req_imm,
   input  logic [25:0] req_target,
   input  logic        req_last,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic [8:0]  word_count,
   output logic        done,
   output logic        full,
   output logic        err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_HALT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FULL  = 3'd4;

   logic [2:0]  state;
   logic [7:0]  ptr;
   logic        last_q;
   logic        we_q;
   logic        legal;
   logic [31:0] enc_word;

   always_comb begin
      legal    = 1'b1;
      enc_word = 32'd0;
      case (req_op)
         3'd0: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, req_funct};
         3'd1: enc_word = {6'b100011, req_rs, req_rt, req_imm};
         3'd2: enc_word = {6'b101011, req_rs, req_rt, req_imm};
         3'd3: enc_word = {6'b000100, req_rs, req_rt, req_imm};
         3'd4: enc_word = {6'b000101, req_rs, req_rt, req_imm};
         3'd5: enc_word = {6'b000010, req_target};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= 8'd0;
         word_count <= 9'd0;
         we_q       <= 1'b0;
         imem_addr  <= 8'd0;
         imem_wdata <= 32'd0;
         err        <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (legal) begin
                     we_q       <= 1'b1;
                     imem_addr  <= ptr;
                     imem_wdata <= enc_word;
                     last_q     <= req_last;
                     state      <= S_WRITE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (word_count != 9'd256)
                  word_count <= word_count + 9'd1;
               if (ptr != 8'd255)
                  ptr <= ptr + 8'd1;
               // Halt word goes right after the last instruction, unless that was the final address.
               if (last_q && ptr != 8'd255) begin
                  we_q       <= 1'b1;
                  imem_addr  <= ptr + 8'd1;
                  imem_wdata <= {6'b000010, 18'd0, ptr + 8'd1};
                  state      <= S_HALT;
               end else if (ptr == 8'd255) begin
                  we_q  <= 1'b0;
                  err   <= err | last_q;
                  state <= S_FULL;
               end else begin
                  we_q  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_HALT: begin
               if (word_count != 9'd256)
                  word_count <= word_count + 9'd1;
               we_q  <= 1'b0;
               state <= S_DONE;
            end
            S_DONE, S_FULL: we_q <= 1'b0;
            default: begin
               we_q  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Reset must kill a write already presented in this cycle.
   assign imem_we   = we_q & ~reset;
   assign req_ready = (state == S_IDLE);
   assign done      = (state == S_DONE);
   assign full      = (state == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [4:0]  req_rs, req_rt, req_rd;
   logic [5:0]  req_funct;
   logic [15:0] req_imm;
   logic [25:0] req_target;
   logic        req_last;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  word_count;
   logic        done, full, err;

   instr_encoder dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
      .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target),
      .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .word_count(word_count), .done(done),
      .full(full), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [39:0] exp_q[$];
   int  m_ptr, m_cnt;
   bit  m_err, m_done, m_full;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int op, input int rs, input int rt, input int rd,
                                            input int funct, input int imm, input int target);
      longint w;
      case (op)
         0: w = rs * 2**21 + rt * 2**16 + rd * 2**11 + funct;
         1: w = 35 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
         2: w = 43 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
         3: w = 4 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
         4: w = 5 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
         default: w = 2 * 2**26 + target;
      endcase
      return w[31:0];
   endfunction

   // Every observed write must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {24'd0, imem_addr, imem_wdata}, 64'd0);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("write_addr", imem_addr, e[39:32]);
            check("write_data", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic model_clear();
      exp_q.delete();
      m_ptr = 0; m_cnt = 0; m_err = 0; m_done = 0; m_full = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
   endtask

   task automatic send(input int op, input int rs, input int rt, input int rd,
                       input int funct, input int imm, input int target, input bit last);
      int waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      req_op = op[2:0]; req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
      req_funct = funct[5:0]; req_imm = imm[15:0]; req_target = target[25:0];
      req_last = last; req_valid = 1'b1;
      @(posedge clk);
      if (op >= 6) begin
         m_err = 1;
      end else begin
         exp_q.push_back({m_ptr[7:0], ref_word(op, rs, rt, rd, funct, imm, target)});
         m_cnt++;
         if (last) begin
            if (m_ptr == 255) begin
               m_err = 1; m_full = 1;
            end else begin
               exp_q.push_back({8'(m_ptr + 1), 32'(2 * 2**26 + m_ptr + 1)});
               m_cnt++; m_done = 1;
            end
         end else if (m_ptr == 255) begin
            m_full = 1;
         end else begin
            m_ptr++;
         end
      end
      #1 req_valid = 1'b0;
      if (op >= 6) begin
         check("illegal_ready", req_ready, 1);
         check("illegal_err", err, 1);
      end else begin
         check("ready_in_write", req_ready, 0);
      end
   endtask

   task automatic send_rand(input int op, input bit last);
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 2**26 - 1), last);
   endtask

   task automatic settle_check(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_count"}, word_count, m_cnt);
      check({tag, "_done"}, done, m_done);
      check({tag, "_full"}, full, m_full);
      check({tag, "_err"}, err, m_err);
      check({tag, "_ready"}, req_ready, !(m_done || m_full));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, req_ready, 1);
      check({tag, "_we"}, imem_we, 0);
      check({tag, "_addr"}, imem_addr, 0);
      check({tag, "_wdata"}, imem_wdata, 0);
      check({tag, "_count"}, word_count, 0);
      check({tag, "_flags"}, {done, full, err}, 3'b000);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0;
      req_funct = '0; req_imm = '0; req_target = '0; req_last = 1'b0;
      model_clear();

      do_reset();
      check_reset_values("reset");

      // R-type add $3,$1,$2
      send(0, 1, 2, 3, 32'h20, 0, 0, 0);
      check("rtype_word_model", exp_q.size(), 1);
      settle_check("rtype");

      do_reset();
      send(1, 4, 5, 0, 0, 16'h0010, 0, 0);
      send(2, 4, 6, 0, 0, 16'hFFFC, 0, 0);
      settle_check("lw_sw");

      do_reset();
      send(3, 1, 2, 0, 0, 3, 0, 1);
      settle_check("beq_last");

      do_reset();
      send(7, 0, 0, 0, 0, 0, 0, 1);
      settle_check("illegal");
      send(5, 0, 0, 0, 0, 0, 32'h40, 0);
      settle_check("jump_after_illegal");

      do_reset();
      for (int i = 0; i < 256; i++) send_rand($urandom_range(0, 5), 0);
      settle_check("fill");

      do_reset();
      for (int i = 0; i < 256; i++) send_rand($urandom_range(0, 5), i == 255);
      settle_check("fill_last");

      // Reset landing on the WRITE cycle must suppress the write.
      do_reset();
      send(0, 1, 2, 3, 32'h20, 0, 0, 0);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("reset_in_write_we", imem_we, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      check_reset_values("after_write_reset");
      send(4, 7, 8, 0, 0, 16'h1234, 0, 0);
      settle_check("post_reset");

      for (int r = 0; r < 8; r++) begin
         int n;
         do_reset();
         n = $urandom_range(1, 30);
         for (int i = 0; i < n; i++)
            send_rand($urandom_range(0, 7), (i == n - 1) && ($urandom_range(0, 1) == 1));
         settle_check("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
